// File: rtl/oflow_core_define.sv
// Shared oflow core definitions: frame scheduler state type and core-wide sizing constants.
package oflow_core_define;

    localparam int unsigned PE_NUM                = 8;
    localparam int unsigned SET_LEN               = 4;
    localparam int unsigned TOTAL_FRAME_NUM_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        FE_START,
        FE_WAIT,
        REG_START,
        REG_WAIT,
        DONE
    } frame_state_e;

endpackage

// File: rtl/oflow_frame_counter.sv
// Frame counter for the oflow core. Zero marks the first frame, so the wrap skips zero.
module oflow_frame_counter #(
    parameter int unsigned TOTAL_FRAME_NUM_WIDTH = oflow_core_define::TOTAL_FRAME_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset_N,
    input  logic                             inc_en,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num
);

    logic [TOTAL_FRAME_NUM_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_en) begin
            // All-ones wraps to 1 so registration never re-enters first-frame mode.
            if (cnt_q == '1) begin
                cnt_d = TOTAL_FRAME_NUM_WIDTH'(1);
            end else begin
                cnt_d = cnt_q + TOTAL_FRAME_NUM_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_num = cnt_q;

endmodule

// File: rtl/oflow_frame_scheduler.sv
// Frame-level controller: per-set feature extraction, one registration pass, frame counting.
// Optional watchdog with sticky wd_error when OFLOW_FRAME_SCHED_WATCHDOG_EN is defined.
module oflow_frame_scheduler #(
    parameter int unsigned PE_NUM                = oflow_core_define::PE_NUM,
    parameter int unsigned OBJ_LEN               = 7,
    parameter int unsigned SET_LEN               = oflow_core_define::SET_LEN,
`ifdef OFLOW_FRAME_SCHED_WATCHDOG_EN
    parameter int unsigned WD_LEN                = 12,
`endif
    parameter int unsigned TOTAL_FRAME_NUM_WIDTH = oflow_core_define::TOTAL_FRAME_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset_N,
    input  logic                             start_frame,
    input  logic [OBJ_LEN-1:0]               num_of_objects,
    input  logic                             done_fe,
    input  logic                             done_registration,
    output logic                             start_fe,
    output logic [SET_LEN-1:0]               fe_set_sel,
    output logic                             start_registration,
    output logic [SET_LEN-1:0]               num_of_sets,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num,
    output logic                             busy,
    output logic                             done_frame
`ifdef OFLOW_FRAME_SCHED_WATCHDOG_EN
    ,
    output logic                             wd_error
`endif
);

    import oflow_core_define::*;

    localparam int unsigned PeShift = $clog2(PE_NUM);

    frame_state_e       state_q, state_d;
    logic [SET_LEN-1:0] set_cnt_q, set_cnt_d;
    logic [SET_LEN-1:0] num_sets_q, num_sets_d;
    logic [OBJ_LEN:0]   obj_round;
    logic [SET_LEN-1:0] sets_calc;
    logic               frame_inc;

    // One extra bit keeps the round-up sum from overflowing.
    assign obj_round = {1'b0, num_of_objects} + (OBJ_LEN+1)'(PE_NUM - 1);
    assign sets_calc = SET_LEN'(obj_round >> PeShift);

`ifdef OFLOW_FRAME_SCHED_WATCHDOG_EN
    logic [WD_LEN-1:0] wd_cnt_q, wd_cnt_d;
    logic              wd_err_q, wd_err_d;
    logic              waiting;

    assign waiting = (state_q == FE_WAIT) || (state_q == REG_WAIT);
`endif

    always_comb begin
        state_d    = state_q;
        set_cnt_d  = set_cnt_q;
        num_sets_d = num_sets_q;
        frame_inc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    num_sets_d = sets_calc;
                    set_cnt_d  = '0;
                    state_d    = (sets_calc != '0) ? FE_START : DONE;
                end
            end
            FE_START: state_d = FE_WAIT;
            FE_WAIT: begin
                if (done_fe) begin
                    if (set_cnt_q == num_sets_q - SET_LEN'(1)) begin
                        state_d = REG_START;
                    end else begin
                        set_cnt_d = set_cnt_q + SET_LEN'(1);
                        state_d   = FE_START;
                    end
                end
            end
            REG_START: state_d = REG_WAIT;
            REG_WAIT: begin
                if (done_registration) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_inc = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef OFLOW_FRAME_SCHED_WATCHDOG_EN
        wd_err_d = wd_err_q;
        // A done pulse arriving on the timeout cycle still wins.
        if (waiting && (state_d == state_q) && (wd_cnt_q == '1)) begin
            state_d  = IDLE;
            wd_err_d = 1'b1;
        end

        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end else if (waiting) begin
            wd_cnt_d = wd_cnt_q + WD_LEN'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            set_cnt_q  <= '0;
            num_sets_q <= '0;
        end else begin
            state_q    <= state_d;
            set_cnt_q  <= set_cnt_d;
            num_sets_q <= num_sets_d;
        end
    end

`ifdef OFLOW_FRAME_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_error = wd_err_q;
`endif

    oflow_frame_counter #(
        .TOTAL_FRAME_NUM_WIDTH(TOTAL_FRAME_NUM_WIDTH)
    ) u_frame_counter (
        .clk      (clk),
        .reset_N  (reset_N),
        .inc_en   (frame_inc),
        .frame_num(frame_num)
    );

    assign start_fe           = (state_q == FE_START);
    assign start_registration = (state_q == REG_START);
    assign done_frame         = (state_q == DONE);
    assign busy               = (state_q != IDLE);
    assign fe_set_sel         = set_cnt_q;
    assign num_of_sets        = num_sets_q;

endmodule
